// File: rtl/oc_bus_arbiter_if.sv
// Signal bundle between requesters, the arbiter and the open-collector driver bank.
// Latency: none, wires only.
// Backpressure: none; requesters hold req until served, the grant is the only flow control.
interface oc_bus_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0] req;    // level request per requester
    logic [N-1:0] dat;    // 0 = pull the shared line low while granted
    logic [N-1:0] gnt;    // registered one-hot grant
    logic [N-1:0] drv;    // to the sn74ls07 A inputs, 1 = released
    logic         bus;    // wired-AND line after the buffers and pullup
    logic         busy;   // grant held or line settling
    logic         fault;  // line stuck low with every driver released

    // Arbiter side
    modport slave (
        input  req, dat, bus,
        output gnt, drv, busy, fault
    );

    // Requester / board side
    modport master (
        output req, dat, bus,
        input  gnt, drv, busy, fault
    );
endinterface

// File: rtl/oc_bus_arbiter.sv
// Round-robin owner selection for one shared open-collector line, with pullup settle and stuck-low detection.
// Latency: req -> gnt 1 cycle from IDLE; after a release the line settles SETTLE cycles before the next grant.
// Backpressure: requests are level-held and wait through HOLD/RELEASE/FAULT; a grant is cut after TIMEOUT cycles.
module oc_bus_arbiter #(
    parameter int N       = 4,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            clr_n,
    oc_bus_arbiter_if.slave bus_if
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE + 1);

    localparam logic [HW-1:0] HOLD_LAST   = HW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [IW:0]   N_V         = (IW + 1)'(N);
    localparam logic [N-1:0]  ONE         = {{(N - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;     // first index scanned at the next IDLE
    logic [IW-1:0]   gidx_q, gidx_d;   // index currently granted
    logic [HW-1:0]   hold_q, hold_d;   // cycles spent in HOLD
    logic [SW-1:0]   cnt_q, cnt_d;     // settle count in RELEASE, bus-high run in FAULT

    logic [2*N-1:0]  req2;
    logic [N-1:0]    rot;
    logic [IW-1:0]   off;
    logic [IW-1:0]   pick;

    // Reduce an index sum back into 0..N-1 (works for non power-of-two N)
    function automatic logic [IW-1:0] wrap_n(input logic [IW:0] v);
        return (v >= N_V) ? IW'(v - N_V) : v[IW-1:0];
    endfunction

    // Rotate requests so ptr sits at bit 0, then take the lowest set bit
    always_comb begin
        req2 = {bus_if.req, bus_if.req};
        rot  = req2[{1'b0, ptr_q} +: N];
        off  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IW'(k);
            end
        end
        pick = wrap_n({1'b0, ptr_q} + {1'b0, off});
    end

    // State and datapath registers; reset releases the line without waiting for a clock
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; an unknown bus sample is treated as low so it lands in FAULT
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|bus_if.req) begin
                    state_d = HOLD;
                    gidx_d  = pick;
                    gnt_d   = ONE << pick;
                    hold_d  = '0;
                end
            end
            HOLD: begin
                hold_d = hold_q + 1'b1;
                // Owner letting go and timeout hitting together is one ordinary release
                if (!bus_if.req[gidx_q] || (hold_q == HOLD_LAST)) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    ptr_d   = wrap_n({1'b0, gidx_q} + 1'b1);
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (bus_if.bus == 1'b1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = FAULT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAULT: begin
                if (bus_if.bus == 1'b1) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        endcase
    end

    // Outputs: only the granted buffer may follow its data, all others stay released
    always_comb begin
        bus_if.gnt   = gnt_q;
        bus_if.drv   = ~(gnt_q & ~bus_if.dat);
        bus_if.busy  = (state_q == HOLD) || (state_q == RELEASE);
        bus_if.fault = (state_q == FAULT);
    end

endmodule
